block_lanes: RTL and testbench

- Parametrised successor to the single falling-block mover.
- Manages NUM_LANES independent falling blocks with a round-robin spawn scheduler, programmable fall speed, synchronous per-lane collision handling, hit/miss counters and a level-end condition.
- Sits between game control (block_ready, speed, restart) and the collision/sprite logic; clocked once per video frame.

---
 rtl/block_lanes_if.sv | 33 +++
 rtl/block_lanes.sv | 193 +++++++++++++++++++
 tb/tb_block_lanes.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/block_lanes_if.sv
// block_lanes_if: groups the game-control and sprite-side signals of block_lanes.
//   master : game control / testbench side (drives restart, block_ready, speed,
//            Collision, Lane_X_Center; observes positions, counters, end_level)
//   slave  : block_lanes itself
// BlockY / BlockX / Lane_X_Center are packed [lane][10 bits], so lane i sits at
// flat bits [10i+9:10i].
interface block_lanes_if #(
    parameter int NUM_LANES = 4,
    parameter int SPEED_W   = 3,
    parameter int CNT_W     = 8
);
    logic                       restart;
    logic                       block_ready;
    logic [SPEED_W-1:0]         speed;
    logic [NUM_LANES-1:0]       Collision;
    logic [NUM_LANES-1:0][9:0]  Lane_X_Center;
    logic [NUM_LANES-1:0][9:0]  BlockX;
    logic [NUM_LANES-1:0][9:0]  BlockY;
    logic [NUM_LANES-1:0]       block_active;
    logic [CNT_W-1:0]           hit_count;
    logic [CNT_W-1:0]           miss_count;
    logic                       end_level;

    modport master (
        output restart, block_ready, speed, Collision, Lane_X_Center,
        input  BlockX, BlockY, block_active, hit_count, miss_count, end_level
    );

    modport slave (
        input  restart, block_ready, speed, Collision, Lane_X_Center,
        output BlockX, BlockY, block_active, hit_count, miss_count, end_level
    );
endinterface

// File: rtl/block_lanes.sv
// block_lanes: NUM_LANES independent falling blocks, one per lane, with a
// round-robin spawn scheduler, per-lane collision retire, saturating hit/miss
// counters and a sticky level-end flag. Clocked once per video frame.
//   frame_clk : frame-rate clock
//   Reset     : asynchronous active-low reset
//   bus       : block_lanes_if.slave (control inputs, positions, counters)

// One lane: IDLE <-> FALL. hit_o / miss_o flag the retire that happens on the
// coming edge so the top can count it on that same edge.
module block_lane #(
    parameter int Y_MAX   = 479,
    parameter int SPEED_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               restart_i,
    input  logic               ready_i,
    input  logic               spawn_i,
    input  logic               collision_i,
    input  logic [SPEED_W-1:0] speed_i,
    output logic [9:0]         y_o,
    output logic               active_o,
    output logic               hit_o,
    output logic               miss_o
);
    typedef enum logic {IDLE, FALL} state_e;

    state_e      state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] next_y;

    // 11-bit sum so a step past the bottom can never wrap back on screen
    assign next_y = {1'b0, y_q} + 11'(speed_i);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        hit_o   = 1'b0;
        miss_o  = 1'b0;
        case (state_q)
            IDLE: begin
                y_d = '0;
                if (spawn_i) state_d = FALL;
            end
            FALL: begin
                // collision outranks both freeze and overflow
                if (collision_i) begin
                    state_d = IDLE;
                    y_d     = '0;
                    hit_o   = 1'b1;
                end else if (ready_i) begin
                    if (next_y > 11'(Y_MAX)) begin
                        state_d = IDLE;
                        y_d     = '0;
                        miss_o  = 1'b1;
                    end else begin
                        y_d = next_y[9:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = '0;
            end
        endcase
        if (restart_i) begin
            state_d = IDLE;
            y_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y_o      = y_q;
    assign active_o = (state_q == FALL);
endmodule

module block_lanes #(
    parameter int NUM_LANES    = 4,
    parameter int Y_MAX        = 479,
    parameter int SPEED_W      = 3,
    parameter int SPAWN_GAP    = 60,
    parameter int LEVEL_BLOCKS = 16,
    parameter int CNT_W        = 8
) (
    input  logic          frame_clk,
    input  logic          Reset,
    block_lanes_if.slave  bus
);
    localparam int TMR_W = $clog2(SPAWN_GAP + 1);
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SPN_W = $clog2(LEVEL_BLOCKS + 1);
    localparam int SUM_W = CNT_W + 4;

    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [SPN_W-1:0]     spawned_q, spawned_d;
    logic [CNT_W-1:0]     hit_q, hit_d, miss_q, miss_d;
    logic                 end_q, end_d;
    logic [NUM_LANES-1:0] spawn, active, lane_hit, lane_miss;
    logic [SPEED_W-1:0]   eff_speed;
    logic                 sched_run;

    // add the number of set event bits, clamping at all-ones
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [NUM_LANES-1:0] ev);
        logic [SUM_W-1:0] s;
        s = SUM_W'(base);
        for (int i = 0; i < NUM_LANES; i++) s = s + SUM_W'(ev[i]);
        return (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign eff_speed = (bus.speed == '0) ? SPEED_W'(1) : bus.speed;
    assign sched_run = bus.block_ready && !end_q &&
                       (spawned_q < SPN_W'(LEVEL_BLOCKS));

    always_comb begin
        tmr_d     = tmr_q;
        ptr_d     = ptr_q;
        spawned_d = spawned_q;
        spawn     = '0;
        // active is pre-edge state, so a lane retiring this edge still blocks
        end_d     = end_q || ((spawned_q == SPN_W'(LEVEL_BLOCKS)) && (active == '0));
        hit_d     = sat_add(hit_q, lane_hit);
        miss_d    = sat_add(miss_q, lane_miss);
        if (sched_run) begin
            if (tmr_q == TMR_W'(SPAWN_GAP - 1)) begin
                tmr_d     = '0;
                spawn[ptr_q] = !active[ptr_q];
                spawned_d = spawned_q + SPN_W'(1);
                ptr_d     = (ptr_q == PTR_W'(NUM_LANES - 1)) ? '0 : ptr_q + PTR_W'(1);
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
        if (bus.restart) begin
            tmr_d     = '0;
            ptr_d     = '0;
            spawned_d = '0;
            end_d     = 1'b0;
            hit_d     = '0;
            miss_d    = '0;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            tmr_q     <= '0;
            ptr_q     <= '0;
            spawned_q <= '0;
            end_q     <= 1'b0;
            hit_q     <= '0;
            miss_q    <= '0;
        end else begin
            tmr_q     <= tmr_d;
            ptr_q     <= ptr_d;
            spawned_q <= spawned_d;
            end_q     <= end_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        block_lane #(.Y_MAX(Y_MAX), .SPEED_W(SPEED_W)) u_lane (
            .clk_i       (frame_clk),
            .rst_ni      (Reset),
            .restart_i   (bus.restart),
            .ready_i     (bus.block_ready),
            .spawn_i     (spawn[g]),
            .collision_i (bus.Collision[g]),
            .speed_i     (eff_speed),
            .y_o         (bus.BlockY[g]),
            .active_o    (active[g]),
            .hit_o       (lane_hit[g]),
            .miss_o      (lane_miss[g])
        );
    end

    assign bus.BlockX       = bus.Lane_X_Center;
    assign bus.block_active = active;
    assign bus.hit_count    = hit_q;
    assign bus.miss_count   = miss_q;
    assign bus.end_level    = end_q;
endmodule

// File: tb/tb_block_lanes.sv
// Bench for block_lanes: 4 lanes, SPAWN_GAP=4, LEVEL_BLOCKS=6, 2-bit counters
// (so saturation is reachable). A frame-level model predicts every output each
// cycle; literal checks along the directed timeline pin the model.
module tb_block_lanes;
    localparam int NL  = 4;
    localparam int YM  = 479;
    localparam int SW  = 3;
    localparam int GAP = 4;
    localparam int LB  = 6;
    localparam int CW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic frame_clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    block_lanes_if #(.NUM_LANES(NL), .SPEED_W(SW), .CNT_W(CW)) bus ();

    block_lanes #(
        .NUM_LANES(NL), .Y_MAX(YM), .SPEED_W(SW),
        .SPAWN_GAP(GAP), .LEVEL_BLOCKS(LB), .CNT_W(CW)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_y[NL];
    bit m_act[NL];
    int m_hit, m_miss, m_tmr, m_ptr, m_spn;
    bit m_end;

    task automatic m_clear();
        for (int i = 0; i < NL; i++) begin
            m_y[i] = 0;
            m_act[i] = 0;
        end
        m_hit = 0; m_miss = 0; m_tmr = 0; m_ptr = 0; m_spn = 0; m_end = 0;
    endtask

    task automatic m_step();
        int es, hits, misses, ny;
        bit busy[NL];
        bit all_idle, old_end;
        es = (bus.speed == 0) ? 1 : int'(bus.speed);
        hits = 0; misses = 0; all_idle = 1; old_end = m_end;
        for (int i = 0; i < NL; i++) begin
            busy[i] = m_act[i];
            if (m_act[i]) all_idle = 0;
        end
        if (m_spn == LB && all_idle) m_end = 1;
        for (int i = 0; i < NL; i++) begin
            if (!m_act[i]) continue;
            if (bus.Collision[i]) begin
                m_act[i] = 0; m_y[i] = 0; hits++;
            end else if (bus.block_ready) begin
                ny = m_y[i] + es;
                if (ny > YM) begin
                    m_act[i] = 0; m_y[i] = 0; misses++;
                end else m_y[i] = ny;
            end
        end
        if (bus.block_ready && !old_end && m_spn < LB) begin
            if (m_tmr == GAP - 1) begin
                m_tmr = 0;
                if (!busy[m_ptr]) begin
                    m_act[m_ptr] = 1; m_y[m_ptr] = 0;
                end
                m_spn++;
                m_ptr = (m_ptr + 1) % NL;
            end else m_tmr++;
        end
        m_hit  = (m_hit + hits > CMAX) ? CMAX : m_hit + hits;
        m_miss = (m_miss + misses > CMAX) ? CMAX : m_miss + misses;
    endtask

    always @(posedge frame_clk or negedge Reset) begin
        if (!Reset || bus.restart) m_clear();
        else m_step();
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b1;
    always @(posedge frame_clk) begin
        #1;
        if (cmp_en) begin
            for (int i = 0; i < NL; i++) begin
                cmp($sformatf("model_y%0d", i), bus.BlockY[i], m_y[i]);
                cmp($sformatf("model_act%0d", i), bus.block_active[i], m_act[i]);
            end
            cmp("model_hit", bus.hit_count, m_hit);
            cmp("model_miss", bus.miss_count, m_miss);
            cmp("model_end", bus.end_level, m_end);
            cmp("blockx", bus.BlockX, bus.Lane_X_Center);
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge frame_clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        Reset = 1'b0;
        bus.restart = 1'b0;
        bus.block_ready = 1'b0;
        bus.speed = 3'd1;
        bus.Collision = '0;
        bus.Lane_X_Center = {10'd400, 10'd300, 10'd200, 10'd100};
        run(2);
        cmp("rst_y", bus.BlockY, 0);
        cmp("rst_act", bus.block_active, 0);
        cmp("rst_hit", bus.hit_count, 0);
        cmp("rst_end", bus.end_level, 0);

        Reset = 1'b1; bus.block_ready = 1'b1;
        run(4);  cmp("spawn0_act", bus.block_active, 4'b0001);
                 cmp("spawn0_y", bus.BlockY[0], 0);
        run(3);  cmp("fall_y3", bus.BlockY[0], 3);
        run(1);  cmp("spawn1_act", bus.block_active, 4'b0011);

        bus.block_ready = 1'b0;
        run(10); cmp("freeze_y", bus.BlockY[0], 4);
                 cmp("freeze_act", bus.block_active, 4'b0011);
        bus.block_ready = 1'b1;
        bus.Lane_X_Center = {10'd7, 10'd513, 10'd1023, 10'd0};
        run(3);  cmp("timer_frozen", bus.block_active, 4'b0011);
        run(1);  cmp("spawn2_act", bus.block_active, 4'b0111);
                 cmp("resume_y0", bus.BlockY[0], 8);
        run(92); cmp("y0_100", bus.BlockY[0], 100);
                 cmp("all_act", bus.block_active, 4'b1111);

        bus.Collision = 4'b0001;
        run(1);  cmp("hit_act", bus.block_active, 4'b1110);
                 cmp("hit_y0", bus.BlockY[0], 0);
                 cmp("hit_cnt1", bus.hit_count, 1);
        run(1);  cmp("idle_coll_hit", bus.hit_count, 1);
                 cmp("idle_coll_act", bus.block_active, 4'b1110);
                 cmp("y1_98", bus.BlockY[1], 98);

        bus.Collision = '0; bus.speed = 3'd7;
        run(53); cmp("y1_469", bus.BlockY[1], 469);
        bus.speed = 3'd1;
        run(6);  cmp("y1_475", bus.BlockY[1], 475);
        bus.speed = 3'd7;
        run(1);  cmp("miss_cnt1", bus.miss_count, 1);
                 cmp("miss_act", bus.block_active, 4'b1100);
                 cmp("y2_478", bus.BlockY[2], 478);
        bus.speed = 3'd0;
        run(1);  cmp("speed0_y479", bus.BlockY[2], 479);
        run(1);  cmp("miss_cnt2", bus.miss_count, 2);
                 cmp("miss2_act", bus.block_active, 4'b1000);

        bus.speed = 3'd7; bus.Collision = 4'b1000;
        run(1);  cmp("coll_ovf_hit", bus.hit_count, 2);
                 cmp("coll_ovf_miss", bus.miss_count, 2);
                 cmp("end_not_yet", bus.end_level, 0);
        bus.Collision = '0;
        run(1);  cmp("end_set", bus.end_level, 1);
        run(5);  cmp("end_hold", bus.end_level, 1);
                 cmp("end_no_spawn", bus.block_active, 0);

        bus.restart = 1'b1;
        run(1);  bus.restart = 1'b0;
        cmp("restart_end", bus.end_level, 0);
        cmp("restart_hit", bus.hit_count, 0);
        cmp("restart_miss", bus.miss_count, 0);
        bus.speed = 3'd1;
        run(16); cmp("lvl2_all_act", bus.block_active, 4'b1111);
        bus.Collision = 4'b1111;
        run(1);  bus.Collision = '0;
        cmp("sat_hit", bus.hit_count, 3);
        cmp("sat_act", bus.block_active, 0);
        run(8);  cmp("lvl2_respawn", bus.block_active, 4'b0011);
        bus.Collision = 4'b0001;
        run(1);  bus.Collision = '0;
        cmp("sat_hold", bus.hit_count, 3);
        cmp("sat_hold_act", bus.block_active, 4'b0010);

        #1 Reset = 1'b0;
        #1;
        cmp("async_y", bus.BlockY, 0);
        cmp("async_act", bus.block_active, 0);
        cmp("async_hit", bus.hit_count, 0);
        cmp("async_end", bus.end_level, 0);
        run(2);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
